// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: opcode encoding and the
// values the registered outputs take while the block is held in reset.
package alu_pkg;

  typedef enum logic [4:0] {
    ALU_AND = 5'd0,
    ALU_OR  = 5'd1,
    ALU_ADD = 5'd2,
    ALU_INC = 5'd3,
    ALU_DEC = 5'd4,
    ALU_NOT = 5'd5,
    ALU_SUB = 5'd6,
    ALU_XOR = 5'd7,
    ALU_SHL = 5'd8,
    ALU_SHR = 5'd9
  } alu_op_e;

  // Reset state of the flags; the result register always resets to zero,
  // which is why the zero flag resets high.
  localparam logic RST_C = 1'b0;
  localparam logic RST_Z = 1'b1;

endpackage

// File: rtl/alu_comb.sv
// Combinational core of the ALU: computes result, carry/borrow/shift-out
// flag and zero flag for the selected operation. No state.
module alu_comb
  import alu_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic [4:0]       op,
  input  logic             f,
  output logic [ANCHO-1:0] r,
  output logic             c,
  output logic             z
);

  localparam logic [ANCHO-1:0] WIDTH_VAL = ANCHO'(ANCHO);
  localparam logic [ANCHO-1:0] ONES      = '1;

  logic [ANCHO-1:0] x;
  logic [ANCHO:0]   shl_ext;
  logic [ANCHO:0]   shr_ext;
  logic [ANCHO-1:0] fill_lo;
  logic [ANCHO-1:0] fill_hi;

  // Single-operand ops work on A or B depending on the flag input.
  assign x = f ? b : a;

  // Shifting A with one extra guard bit leaves the last bit shifted out in
  // that guard position, valid for shift amounts 1..ANCHO.
  assign shl_ext = {1'b0, a} << b;
  assign shr_ext = {a, 1'b0} >> b;

  // Masks of the vacated positions, filled when the fill bit is set.
  assign fill_lo = f ? ~(ONES << b) : '0;
  assign fill_hi = f ? ~(ONES >> b) : '0;

  // Operation decode; undefined opcodes fall through to a zero result.
  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave it unassigned and infer a latch.
    r = '0;
    c = 1'b0;
    case (alu_op_e'(op))
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: {c, r} = {1'b0, a} + {1'b0, b} + {{ANCHO{1'b0}}, f};
      ALU_INC: {c, r} = {1'b0, x} + {{ANCHO{1'b0}}, 1'b1};
      // Top bit of the widened difference is the borrow.
      ALU_DEC: {c, r} = {1'b0, x} - {{ANCHO{1'b0}}, 1'b1};
      ALU_NOT: r = ~x;
      ALU_SUB: {c, r} = {1'b0, a} - {1'b0, b} - {{ANCHO{1'b0}}, f};
      ALU_XOR: r = a ^ b;
      ALU_SHL: begin
        if (b == '0) begin
          r = a;
        end else if (b > WIDTH_VAL) begin
          r = {ANCHO{f}};
          c = f;
        end else begin
          r = shl_ext[ANCHO-1:0] | fill_lo;
          c = shl_ext[ANCHO];
        end
      end
      ALU_SHR: begin
        if (b == '0) begin
          r = a;
        end else if (b > WIDTH_VAL) begin
          r = {ANCHO{f}};
          c = f;
        end else begin
          r = shr_ext[ANCHO:1] | fill_hi;
          c = shr_ext[0];
        end
      end
      default: begin
        r = '0;
        c = 1'b0;
      end
    endcase
    z = (r == '0);
  end

endmodule

// File: rtl/alu_reg.sv
// Execute-stage ALU with registered outputs: the combinational core result
// is captured every rising edge; reset clears the outputs asynchronously.
module alu_reg
  import alu_pkg::*;
#(
  parameter int ANCHO = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ANCHO-1:0] ALUA,
  input  logic [ANCHO-1:0] ALUB,
  input  logic [4:0]       ALUControl,
  input  logic             ALUFlagIn,
  output logic [ANCHO-1:0] ALUResult,
  output logic             C,
  output logic             Z
);

  logic [ANCHO-1:0] r_next;
  logic             c_next;
  logic             z_next;

  alu_comb #(.ANCHO(ANCHO)) u_alu_comb (
    .a  (ALUA),
    .b  (ALUB),
    .op (ALUControl),
    .f  (ALUFlagIn),
    .r  (r_next),
    .c  (c_next),
    .z  (z_next)
  );

  // Output register stage, updated every cycle with no handshake.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so all three outputs take the values
    // computed before this edge, independent of statement order.
    if (rst) begin
      ALUResult <= '0;
      C         <= RST_C;
      Z         <= RST_Z;
    end else begin
      ALUResult <= r_next;
      C         <= c_next;
      Z         <= z_next;
    end
  end

endmodule

// File: tb/tb_alu_reg.sv
// Scoreboard bench for alu_reg (ANCHO=4): the driver pushes hand-computed
// expectations as it applies vectors; the monitor pops and compares one
// cycle later.
module tb_alu_reg;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] alua = '0;
  logic [3:0] alub = '0;
  logic [4:0] alu_control = '0;
  logic       alu_flag_in = 1'b0;
  logic [3:0] alu_result;
  logic       c;
  logic       z;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] r;
    logic       c;
    logic       z;
    string      name;
  } exp_t;

  exp_t exp_q[$];

  alu_reg #(.ANCHO(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ALUA       (alua),
    .ALUB       (alub),
    .ALUControl (alu_control),
    .ALUFlagIn  (alu_flag_in),
    .ALUResult  (alu_result),
    .C          (c),
    .Z          (z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] actual,
                       input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply(input logic [4:0] op, input logic [3:0] a,
                       input logic [3:0] b, input logic f,
                       input logic [3:0] er, input logic ec, input logic ez,
                       input string name);
    exp_t e;
    @(negedge clk);
    alu_control = op;
    alua        = a;
    alub        = b;
    alu_flag_in = f;
    e.r = er;
    e.c = ec;
    e.z = ez;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
  endtask

  // Monitor: outputs are valid just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".R"}, 64'(alu_result), 64'(e.r));
        check({e.name, ".C"}, 64'(c), 64'(e.c));
        check({e.name, ".Z"}, 64'(z), 64'(e.z));
      end
    end
  end

  initial begin
    // Reset state
    #12;
    check("rst.R", 64'(alu_result), 64'h0);
    check("rst.C", 64'(c), 64'h0);
    check("rst.Z", 64'(z), 64'h1);
    @(negedge clk);
    rst = 1'b0;

    //     op  A      B      F     R      C     Z
    apply(5'd0, 4'h2, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0, "and");
    apply(5'd1, 4'h2, 4'h0, 1'b0, 4'h2, 1'b0, 1'b0, "or");
    apply(5'd2, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b1, "add_zero");
    apply(5'd2, 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b1, "add_carry");
    apply(5'd2, 4'h7, 4'h8, 1'b1, 4'h0, 1'b1, 1'b1, "add_cin");
    apply(5'd3, 4'h2, 4'h3, 1'b1, 4'h4, 1'b0, 1'b0, "inc_b");
    apply(5'd3, 4'hF, 4'h3, 1'b0, 4'h0, 1'b1, 1'b1, "inc_wrap");
    apply(5'd4, 4'h2, 4'h3, 1'b1, 4'h2, 1'b0, 1'b0, "dec_b");
    apply(5'd5, 4'h2, 4'h3, 1'b1, 4'hC, 1'b0, 1'b0, "not_b");
    apply(5'd4, 4'h0, 4'h3, 1'b0, 4'hF, 1'b1, 1'b0, "dec_borrow");
    apply(5'd6, 4'h2, 4'h3, 1'b0, 4'hF, 1'b1, 1'b0, "sub_borrow");
    apply(5'd6, 4'h3, 4'h2, 1'b1, 4'h0, 1'b0, 1'b1, "sub_bin");
    apply(5'd6, 4'h2, 4'h2, 1'b1, 4'hF, 1'b1, 1'b0, "sub_bin_borrow");
    apply(5'd7, 4'h2, 4'h3, 1'b0, 4'h1, 1'b0, 1'b0, "xor");
    apply(5'd8, 4'h2, 4'h2, 1'b0, 4'h8, 1'b0, 1'b0, "shl2");
    apply(5'd9, 4'h1, 4'h1, 1'b1, 4'h8, 1'b1, 1'b0, "shr1_fill");
    apply(5'd8, 4'h2, 4'h5, 1'b1, 4'hF, 1'b1, 1'b0, "shl_over");
    apply(5'd8, 4'h9, 4'h4, 1'b0, 4'h0, 1'b1, 1'b1, "shl_width");
    apply(5'd9, 4'h9, 4'h4, 1'b1, 4'hF, 1'b1, 1'b0, "shr_width");
    apply(5'd8, 4'h5, 4'h0, 1'b1, 4'h5, 1'b0, 1'b0, "shl_zero");
    apply(5'd9, 4'hA, 4'h2, 1'b0, 4'h2, 1'b1, 1'b0, "shr2");
    apply(5'd10, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, "undef10");
    apply(5'd31, 4'hF, 4'hF, 1'b1, 4'h0, 1'b0, 1'b1, "undef31");
    apply(5'd1, 4'h5, 4'hA, 1'b0, 4'hF, 1'b0, 1'b0, "or_pre_rst");
    drain();

    // Mid-cycle reset clears outputs without waiting for an edge.
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_async.R", 64'(alu_result), 64'h0);
    check("rst_async.C", 64'(c), 64'h0);
    check("rst_async.Z", 64'(z), 64'h1);

    // Outputs stay cleared across an edge while reset is held.
    @(posedge clk);
    #1;
    check("rst_hold.R", 64'(alu_result), 64'h0);
    check("rst_hold.Z", 64'(z), 64'h1);

    @(negedge clk);
    rst = 1'b0;
    apply(5'd0, 4'h6, 4'hC, 1'b0, 4'h4, 1'b0, 1'b0, "and_post_rst");
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
